// File: rtl/mcu_dmi_req_arbiter.sv
// mcu_dmi_req_arbiter
// Shares the single debug-module register port between the JTAG DMI path
// (single-cycle enable pulses, no backpressure) and a SoC debug requester
// (valid/ready). Only one DM access is in flight at a time. Each access waits
// for dm_rvalid, with a timeout. The response goes back to whichever requester
// owns the access.
//
// Ports
//   clk, rst                      core clock, synchronous active-high reset
//   jtag_reg_en/_wr_en/addr/wdata JTAG request pulse and its payload
//   jtag_rvalid/rdata/err         JTAG response pulse, data and timeout flag
//   jtag_overflow                 sticky: a JTAG pulse arrived while the slot was full
//   soc_req_valid/ready/wr/addr/wdata   SoC request handshake and payload
//   soc_rsp_valid/rdata/err       SoC response pulse, data and timeout flag
//   dm_en/wr_en/addr/wdata        one-cycle DM access strobe and payload
//   dm_rdata/dm_rvalid            DM response
//   busy                          FSM active or a JTAG request is waiting
//
// Build option
//   MCU_DMI_ARB_RR_EN  defined: round-robin between requesters.
//                      undefined: fixed priority, with JTAG always ahead of the SoC.
//
// state | meaning
// IDLE  | pick a requester and latch its request into the issue registers
// ISSUE | dm_en strobe for one cycle; clear the timeout counter
// WAIT  | wait for dm_rvalid or for the timeout
// RESP  | one-cycle response pulse to the owner
module mcu_dmi_req_arbiter #(
   parameter int AW      = 7,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          jtag_reg_en,
   input  logic          jtag_reg_wr_en,
   input  logic [AW-1:0] jtag_addr,
   input  logic [DW-1:0] jtag_wdata,
   output logic          jtag_rvalid,
   output logic [DW-1:0] jtag_rdata,
   output logic          jtag_err,
   output logic          jtag_overflow,
   input  logic          soc_req_valid,
   output logic          soc_req_ready,
   input  logic          soc_req_wr,
   input  logic [AW-1:0] soc_addr,
   input  logic [DW-1:0] soc_wdata,
   output logic          soc_rsp_valid,
   output logic [DW-1:0] soc_rsp_rdata,
   output logic          soc_rsp_err,
   output logic          dm_en,
   output logic          dm_wr_en,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] dm_rdata,
   input  logic          dm_rvalid,
   output logic          busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic OWN_JTAG = 1'b0;
   localparam logic OWN_SOC  = 1'b1;

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   logic [1:0]    state;
   logic          jpend;
   logic          jslot_wr;
   logic [AW-1:0] jslot_addr;
   logic [DW-1:0] jslot_wdata;
   logic          overflow;
   logic          owner;
   logic          iss_wr;
   logic [AW-1:0] iss_addr;
   logic [DW-1:0] iss_wdata;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [7:0]    cnt;
   logic [7:0]    cnt_nxt;
   logic          idle;
   logic          grant_jtag;
   logic          grant_soc;

   assign idle    = (state == S_IDLE);
   assign cnt_nxt = cnt + 8'd1;

`ifdef MCU_DMI_ARB_RR_EN
   logic last_owner;

   // When both requesters are waiting, the one that was not served last wins.
   always_comb begin
      grant_jtag = idle && jpend && (!soc_req_valid || (last_owner == OWN_SOC));
      grant_soc  = idle && soc_req_valid && (!jpend || (last_owner == OWN_JTAG));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_owner <= OWN_JTAG;
      end else if (grant_jtag) begin
         last_owner <= OWN_JTAG;
      end else if (grant_soc) begin
         last_owner <= OWN_SOC;
      end
   end
`else
   always_comb begin
      grant_jtag = idle && jpend;
      grant_soc  = idle && soc_req_valid && !jpend;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         jpend       <= 1'b0;
         jslot_wr    <= 1'b0;
         jslot_addr  <= '0;
         jslot_wdata <= '0;
         overflow    <= 1'b0;
         owner       <= OWN_JTAG;
         iss_wr      <= 1'b0;
         iss_addr    <= '0;
         iss_wdata   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         cnt         <= '0;
      end else begin
         // The slot is free when it is empty or is being handed to the FSM
         // this cycle. A pulse in the grant cycle refills it at once.
         if (jtag_reg_en && (!jpend || grant_jtag)) begin
            jpend       <= 1'b1;
            jslot_wr    <= jtag_reg_wr_en;
            jslot_addr  <= jtag_addr;
            jslot_wdata <= jtag_wdata;
         end else if (jtag_reg_en) begin
            overflow <= 1'b1;
         end else if (grant_jtag) begin
            jpend <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (grant_jtag) begin
                  iss_wr    <= jslot_wr;
                  iss_addr  <= jslot_addr;
                  iss_wdata <= jslot_wdata;
                  owner     <= OWN_JTAG;
                  state     <= S_ISSUE;
               end else if (grant_soc) begin
                  iss_wr    <= soc_req_wr;
                  iss_addr  <= soc_addr;
                  iss_wdata <= soc_wdata;
                  owner     <= OWN_SOC;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt   <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // A response in the last allowed cycle still counts as a success.
               if (dm_rvalid) begin
                  rsp_rdata <= iss_wr ? '0 : dm_rdata;
                  rsp_err   <= 1'b0;
                  state     <= S_RESP;
               end else if (cnt_nxt == TO_LIMIT) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign dm_en    = (state == S_ISSUE);
   assign dm_wr_en = dm_en & iss_wr;
   assign dm_addr  = dm_en ? iss_addr  : '0;
   assign dm_wdata = dm_en ? iss_wdata : '0;

   assign jtag_rvalid   = (state == S_RESP) && (owner == OWN_JTAG);
   assign jtag_rdata    = jtag_rvalid ? rsp_rdata : '0;
   assign jtag_err      = jtag_rvalid & rsp_err;
   assign jtag_overflow = overflow;

   assign soc_req_ready = grant_soc;
   assign soc_rsp_valid = (state == S_RESP) && (owner == OWN_SOC);
   assign soc_rsp_rdata = soc_rsp_valid ? rsp_rdata : '0;
   assign soc_rsp_err   = soc_rsp_valid & rsp_err;

   assign busy = !idle || jpend;

endmodule

// File: tb/tb_mcu_dmi_req_arbiter.sv
module tb_mcu_dmi_req_arbiter;

   localparam int AW      = 7;
   localparam int DW      = 32;
   localparam int TIMEOUT = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          jtag_reg_en = 1'b0;
   logic          jtag_reg_wr_en = 1'b0;
   logic [AW-1:0] jtag_addr = '0;
   logic [DW-1:0] jtag_wdata = '0;
   logic          jtag_rvalid;
   logic [DW-1:0] jtag_rdata;
   logic          jtag_err;
   logic          jtag_overflow;
   logic          soc_req_valid = 1'b0;
   logic          soc_req_ready;
   logic          soc_req_wr = 1'b0;
   logic [AW-1:0] soc_addr = '0;
   logic [DW-1:0] soc_wdata = '0;
   logic          soc_rsp_valid;
   logic [DW-1:0] soc_rsp_rdata;
   logic          soc_rsp_err;
   logic          dm_en;
   logic          dm_wr_en;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata = '0;
   logic          dm_rvalid = 1'b0;
   logic          busy;

   mcu_dmi_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .jtag_reg_en(jtag_reg_en), .jtag_reg_wr_en(jtag_reg_wr_en),
      .jtag_addr(jtag_addr), .jtag_wdata(jtag_wdata),
      .jtag_rvalid(jtag_rvalid), .jtag_rdata(jtag_rdata), .jtag_err(jtag_err),
      .jtag_overflow(jtag_overflow),
      .soc_req_valid(soc_req_valid), .soc_req_ready(soc_req_ready),
      .soc_req_wr(soc_req_wr), .soc_addr(soc_addr), .soc_wdata(soc_wdata),
      .soc_rsp_valid(soc_rsp_valid), .soc_rsp_rdata(soc_rsp_rdata), .soc_rsp_err(soc_rsp_err),
      .dm_en(dm_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_jrv = 0, n_srv = 0, n_dmen = 0, n_hs = 0;
   always @(negedge clk) begin
      if (jtag_rvalid) n_jrv <= n_jrv + 1;
      if (soc_rsp_valid) n_srv <= n_srv + 1;
      if (dm_en) n_dmen <= n_dmen + 1;
      if (soc_req_valid && soc_req_ready) n_hs <= n_hs + 1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        soc;
      logic        wr;
      logic [6:0]  addr;
      logic [31:0] wdata;
      int          dly;       // cycles after dm_en to assert dm_rvalid, 0 = never
      logic [31:0] dm_data;
      int          late;      // cycles after the response to inject a stray dm_rvalid, 0 = none
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;   // cycles from dm_en to the response pulse
   } vec_t;

   vec_t vecs[7];

   function automatic vec_t mk(input logic soc, input logic wr, input logic [6:0] addr,
                               input logic [31:0] wdata, input int dly, input logic [31:0] dmd,
                               input int late, input logic [31:0] er, input logic ee, input int el);
      vec_t v;
      v.soc = soc; v.wr = wr; v.addr = addr; v.wdata = wdata; v.dly = dly;
      v.dm_data = dmd; v.late = late; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
      return v;
   endfunction

   // One cycle forward; single-cycle pulses fall back to 0 unless re-driven.
   task automatic adv();
      @(posedge clk);
      #1;
      jtag_reg_en = 1'b0;
      dm_rvalid   = 1'b0;
      dm_rdata    = '0;
   endtask

   task automatic jpulse(input logic wr, input logic [6:0] addr, input logic [31:0] wdata);
      jtag_reg_en    = 1'b1;
      jtag_reg_wr_en = wr;
      jtag_addr      = addr;
      jtag_wdata     = wdata;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " dm_ctl"}, {23'd0, dm_en, dm_wr_en, dm_addr}, 32'd0);
      chk({tag, " dm_wdata"}, dm_wdata, 32'd0);
      chk({tag, " jtag_rsp"}, {29'd0, jtag_rvalid, jtag_err, jtag_overflow}, 32'd0);
      chk({tag, " jtag_rdata"}, jtag_rdata, 32'd0);
      chk({tag, " soc_rsp"}, {29'd0, soc_req_ready, soc_rsp_valid, soc_rsp_err}, 32'd0);
      chk({tag, " soc_rdata"}, soc_rsp_rdata, 32'd0);
      chk({tag, " busy"}, busy, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      adv();
      rst = 1'b1;
      soc_req_valid = 1'b0;
      soc_req_wr = 1'b0;
      soc_addr = '0;
      soc_wdata = '0;
      adv();
      adv();
      rst = 1'b0;
      #1;
      check_zero(tag);
   endtask

   task automatic wait_dm(input string nm, output bit got);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         adv();
         #1;
         if (dm_en) got = 1'b1;
      end
      chk(nm, got, 1'b1);
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      int t_req, t_en, t_rsp;
      bit got;
      v = vecs[i];
      adv();
      t_req = cyc;
      if (v.soc) begin
         soc_req_valid = 1'b1; soc_req_wr = v.wr; soc_addr = v.addr; soc_wdata = v.wdata;
      end else begin
         jpulse(v.wr, v.addr, v.wdata);
      end
      #1;
      chk($sformatf("v%0d req_ready", i), soc_req_ready, v.soc);
      got = 1'b0;
      t_en = 0;
      for (int k = 0; k < 6 && !got; k++) begin
         adv();
         soc_req_valid = 1'b0;
         #1;
         if (dm_en) begin
            got = 1'b1;
            t_en = cyc;
         end
      end
      chk($sformatf("v%0d dm_en_seen", i), got, 1'b1);
      chk($sformatf("v%0d dm_en_lat", i), t_en - t_req, v.soc ? 1 : 2);
      chk($sformatf("v%0d dm_wr_en", i), dm_wr_en, v.wr);
      chk($sformatf("v%0d dm_addr", i), dm_addr, v.addr);
      chk($sformatf("v%0d dm_wdata", i), dm_wdata, v.wdata);
      chk($sformatf("v%0d soc_ready_busy", i), soc_req_ready, 1'b0);

      got = 1'b0;
      t_rsp = 0;
      for (int k = 1; k <= TIMEOUT + 4 && !got; k++) begin
         adv();
         if (v.dly == k) begin
            dm_rvalid = 1'b1;
            dm_rdata  = v.dm_data;
         end
         #1;
         if (k == 1) chk($sformatf("v%0d dm_addr_idle", i), {dm_en, dm_addr, dm_wdata[7:0]}, 0);
         if (jtag_rvalid || soc_rsp_valid) begin
            got = 1'b1;
            t_rsp = cyc;
            chk($sformatf("v%0d rsp_owner", i), {jtag_rvalid, soc_rsp_valid}, v.soc ? 2'b01 : 2'b10);
            chk($sformatf("v%0d rsp_rdata", i), v.soc ? soc_rsp_rdata : jtag_rdata, v.exp_rdata);
            chk($sformatf("v%0d rsp_err", i), v.soc ? soc_rsp_err : jtag_err, v.exp_err);
         end
      end
      chk($sformatf("v%0d rsp_seen", i), got, 1'b1);
      chk($sformatf("v%0d rsp_lat", i), t_rsp - t_en, v.exp_lat);

      for (int k = 1; k <= 3; k++) begin
         adv();
         if (v.late == k) begin
            dm_rvalid = 1'b1;
            dm_rdata  = '1;
         end
         #1;
         chk($sformatf("v%0d quiet%0d", i, k),
             {dm_en, jtag_rvalid, soc_rsp_valid, |jtag_rdata, |soc_rsp_rdata}, 0);
      end
      chk($sformatf("v%0d busy_end", i), busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit got;
      int base_j, base_s, base_d, hs0;
      vecs[0] = mk(1'b0, 1'b0, 7'h04, 32'h0,        1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 2);
      vecs[1] = mk(1'b1, 1'b1, 7'h10, 32'h1,        3, 32'h12345678, 0, 32'h0,        1'b0, 4);
      vecs[2] = mk(1'b1, 1'b0, 7'h7F, 32'h0,        5, 32'hA5A55A5A, 0, 32'hA5A55A5A, 1'b0, 6);
      vecs[3] = mk(1'b0, 1'b1, 7'h00, 32'hFFFFFFFF, 8, 32'h87654321, 0, 32'h0,        1'b0, 9);
      vecs[4] = mk(1'b0, 1'b0, 7'h2A, 32'h0,        0, 32'h0,        2, 32'h0,        1'b1, 9);
      vecs[5] = mk(1'b1, 1'b0, 7'h3C, 32'h0,        0, 32'h0,        1, 32'h0,        1'b1, 9);
      vecs[6] = mk(1'b0, 1'b0, 7'h55, 32'h0,        8, 32'h0BADF00D, 0, 32'h0BADF00D, 1'b0, 9);

      do_reset("reset");

      for (int i = 0; i < 7; i++) run_vec(i);

      // Pulse in the grant cycle refills the slot without overflow.
      adv(); jpulse(1'b0, 7'h11, 32'h0);
      adv(); jpulse(1'b0, 7'h22, 32'h0);
      #1 chk("same_cycle busy", busy, 1'b1);
      adv(); #1;
      chk("same_cycle overflow", jtag_overflow, 1'b0);
      chk("same_cycle x_issue", {dm_en, dm_addr}, {1'b1, 7'h11});
      adv(); dm_rvalid = 1'b1; dm_rdata = 32'h1111;
      adv(); #1;
      chk("x_rsp", {jtag_rvalid, jtag_rdata}, {1'b1, 32'h1111});
      adv(); #1;
      chk("y_pending busy", busy, 1'b1);
      adv(); #1;
      chk("y_issue", {dm_en, dm_addr}, {1'b1, 7'h22});
      // Two pulses during WAIT: the first fills the slot, the second is dropped.
      adv(); jpulse(1'b0, 7'h33, 32'h0);
      adv(); jpulse(1'b0, 7'h44, 32'h0);
      #1 chk("ovf_not_yet", jtag_overflow, 1'b0);
      adv(); #1;
      chk("ovf_set", jtag_overflow, 1'b1);
      dm_rvalid = 1'b1; dm_rdata = 32'h2222;
      adv(); #1;
      chk("y_rsp", {jtag_rvalid, jtag_rdata}, {1'b1, 32'h2222});
      adv();
      adv(); #1;
      chk("z_issue", {dm_en, dm_addr}, {1'b1, 7'h33});
      adv(); dm_rvalid = 1'b1; dm_rdata = 32'h3333;
      adv(); #1;
      chk("z_rsp", {jtag_rvalid, jtag_rdata}, {1'b1, 32'h3333});
      base_d = n_dmen;
      repeat (8) adv();
      #1;
      chk("dropped_not_issued", n_dmen - base_d, 0);
      chk("ovf_sticky", jtag_overflow, 1'b1);
      chk("ovf_idle busy", busy, 1'b0);

      // Reset in WAIT followed by a late DM response.
      do_reset("reset2");
      adv(); soc_req_valid = 1'b1; soc_req_wr = 1'b0; soc_addr = 7'h21;
      adv(); soc_req_valid = 1'b0;
      #1 chk("rst_wait issue", dm_en, 1'b1);
      adv();
      adv(); rst = 1'b1;
      adv(); rst = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hBEEF;
      base_j = n_jrv; base_s = n_srv;
      #1 check_zero("rst_wait");
      repeat (4) adv();
      #1;
      chk("rst_wait no_rvalid", {n_jrv - base_j, n_srv - base_s}, 0);
      check_zero("rst_wait later");

`ifdef MCU_DMI_ARB_RR_EN
      do_reset("rr_reset");
      hs0 = n_hs;
      adv(); jpulse(1'b0, 7'h05, 32'h0);
      for (int r = 0; r < 5; r++) begin
         wait_dm($sformatf("rr%0d dm_en", r), got);
         chk($sformatf("rr%0d owner_addr", r), dm_addr, (r == 1 || r == 3) ? 7'h33 : 7'h05);
         if (r == 3) soc_req_valid = 1'b0;
         adv();
         if (r == 0) begin
            soc_req_valid = 1'b1; soc_req_wr = 1'b1; soc_addr = 7'h33; soc_wdata = 32'hCAFE;
         end
         if (r < 3) jpulse(1'b0, 7'h05, 32'h0);
         dm_rvalid = 1'b1; dm_rdata = 32'h5;
         adv(); #1;
         chk($sformatf("rr%0d rsp", r), {jtag_rvalid, soc_rsp_valid},
             (r == 1 || r == 3) ? 2'b01 : 2'b10);
         adv();
      end
      chk("rr soc_grants", n_hs - hs0, 2);
`else
      do_reset("fp_reset");
      hs0 = n_hs;
      adv(); jpulse(1'b0, 7'h05, 32'h0);
      adv(); soc_req_valid = 1'b1; soc_req_wr = 1'b1; soc_addr = 7'h33; soc_wdata = 32'hCAFE;
      #1 chk("fp ready_blocked", soc_req_ready, 1'b0);
      for (int r = 0; r < 3; r++) begin
         wait_dm($sformatf("fp%0d dm_en", r), got);
         chk($sformatf("fp%0d jtag_addr", r), dm_addr, 7'h05);
         adv();
         if (r < 2) jpulse(1'b0, 7'h05, 32'h0);
         dm_rvalid = 1'b1; dm_rdata = 32'(r);
         adv(); #1;
         chk($sformatf("fp%0d jtag_rsp", r), {jtag_rvalid, jtag_rdata}, {1'b1, 32'(r)});
         adv(); #1;
         chk($sformatf("fp%0d soc_ready", r), soc_req_ready, r == 2);
      end
      chk("fp soc_starved", n_hs - hs0, 0);
      adv(); soc_req_valid = 1'b0;
      #1;
      chk("fp soc_issue", {dm_en, dm_wr_en, dm_addr}, {1'b1, 1'b1, 7'h33});
      chk("fp soc_wdata", dm_wdata, 32'hCAFE);
      adv(); dm_rvalid = 1'b1; dm_rdata = 32'hFFFF;
      adv(); #1;
      chk("fp soc_rsp", {soc_rsp_valid, soc_rsp_err, jtag_rvalid}, 3'b100);
      chk("fp soc_rdata", soc_rsp_rdata, 32'h0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mcu_dmi_req_arbiter.md
# mcu_dmi_req_arbiter

Core-clock-domain arbiter and sequencer that shares the single debug-module (DM) register access port between two requesters. The first is the JTAG DMI path, which delivers single-cycle, already-synchronized enable pulses. The second is a SoC-side debug requester that uses a valid/ready handshake. The block serializes accesses, issues exactly one DM access at a time, waits for its response with a timeout, and routes read data and status back to the owning requester.

## Interface
- AW, 7: DM register address width
- DW, 32: data width
- TIMEOUT, 255: maximum cycles to wait for dm_rvalid; range 1..255; counter is 8 bits
- clk  in  1  core clock; the only clock
- rst  in  1  synchronous, active-high reset
- jtag_reg_en  in  1  single-cycle request pulse from the DMI sync; no backpressure
- jtag_reg_wr_en  in  1  write qualifier; valid with jtag_reg_en
- jtag_addr  in  AW  request address; valid with jtag_reg_en
- jtag_wdata  in  DW  write data; valid with jtag_reg_en
- jtag_rvalid  out  1  one-cycle response pulse
- jtag_rdata  out  DW  read data; valid with jtag_rvalid
- jtag_err  out  1  timeout flag; valid with jtag_rvalid
- jtag_overflow  out  1  sticky: a JTAG pulse was dropped
- soc_req_valid  in  1  SoC request valid
- soc_req_ready  out  1  SoC request accepted
- soc_req_wr  in  1  write qualifier
- soc_addr  in  AW  request address
- soc_wdata  in  DW  write data
- soc_rsp_valid  out  1  one-cycle response pulse
- soc_rsp_rdata  out  DW  read data
- soc_rsp_err  out  1  timeout flag
- dm_en  out  1  DM access strobe, exactly one cycle
- dm_wr_en  out  1  DM write qualifier; valid with dm_en
- dm_addr  out  AW  DM address
- dm_wdata  out  DW  DM write data
- dm_rdata  in  DW  DM read data; valid with dm_rvalid
- dm_rvalid  in  1  DM response, one cycle; required for reads and writes
- busy  out  1  high whenever state is not IDLE, or a JTAG request is pending

## Operation
- JTAG capture slot: a jtag_reg_en pulse loads wr, addr and wdata into the slot and sets jpend.
  - Pulse while jpend=1 and the slot is not granted that cycle: request dropped, jtag_overflow set.
  - Pulse in the same cycle the slot is granted: the new request is captured and jpend stays 1. No overflow.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If jpend or soc_req_valid is high, select a winner (see Configuration).
  - Latch the winner's wr/addr/wdata into issue registers and record the owner.
  - JTAG win: clear jpend. SoC win: assert soc_req_ready combinationally in this cycle only.
  - Go to ISSUE.
- ISSUE: dm_en=1 for one cycle; dm_wr_en/dm_addr/dm_wdata come from the issue registers. Clear the timeout counter. Go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - dm_rvalid=1: capture dm_rdata (zero for writes), err=0, go to RESP.
  - Counter reaches TIMEOUT with no dm_rvalid: rdata=0, err=1, go to RESP.
  - dm_rvalid and the timeout in the same cycle: dm_rvalid wins, err=0.
- RESP: pulse the owner's rvalid with its rdata/err for one cycle. Go to IDLE.
- dm_rvalid outside WAIT is ignored (late or stray responses).
- DM outputs are zero when dm_en=0. Response data outputs are zero when their rvalid is 0.

## Timing
- Reset: state=IDLE; jpend=0. All outputs 0, including jtag_overflow and busy. Any outstanding DM response is discarded.
- JTAG latency, pulse at cycle N:
  - jpend visible N+1; grant in N+1; dm_en in N+2.
  - dm_rvalid no earlier than N+3; jtag_rvalid one cycle after dm_rvalid (minimum N+4).
- SoC latency: handshake in cycle M; dm_en in M+1; soc_rsp_valid minimum M+3.
- Back-to-back accesses: RESP→IDLE→ISSUE, so minimum spacing between dm_en strobes is 4 cycles.
- soc_req_ready is never high outside IDLE. SoC inputs must stay stable while valid is high and ready is low.
- Timeout response arrives exactly TIMEOUT+1 cycles after dm_en.

## Configuration
- MCU_DMI_ARB_RR_EN defined:
  - Round-robin arbitration with a 1-bit last-owner register (reset value: JTAG).
  - When both requesters are pending, grant the one that was not last granted. A lone requester always wins.
- Undefined: fixed priority; JTAG always wins, and the SoC is granted only when jpend=0.

## Test plan
- JTAG read, addr 0x04; DM returns 0xDEADBEEF 1 cycle after dm_en → dm_en at N+2 with dm_wr_en=0; jtag_rvalid at N+4, rdata 0xDEADBEEF, err=0.
- SoC write, addr 0x10, data 0x1, dm_rvalid after 3 cycles → soc_req_ready for exactly 1 cycle; dm_wr_en=1, dm_wdata=0x1; soc_rsp_valid with err=0, rdata=0.
- Both requesters pending with RR enabled, 4 accesses → grants alternate JTAG, SoC, JTAG, SoC. With RR disabled and JTAG kept pending → SoC is never granted.
- No dm_rvalid, TIMEOUT=8 → owner rvalid 9 cycles after dm_en with err=1, rdata=0. A dm_rvalid injected 2 cycles later is ignored.
- Two JTAG pulses 1 cycle apart while the FSM is in WAIT → jtag_overflow=1 and stays 1; only the first request is issued.
- rst asserted during WAIT, then dm_rvalid → all outputs 0, FSM in IDLE, no rvalid pulse on either requester.
